// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU control codes, the alternate funct7 value and FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SRL  = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_ctrl_e;

  // Selects SUB instead of ADD and SRA instead of SRL.
  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu.sv
// Combinational RV32-style ALU selected by ALUControl, with funct7 choosing SUB/SRA.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [2:0]        alu_ctrl,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  logic signed [DATA_W-1:0] op1_s;
  logic signed [DATA_W-1:0] op2_s;
  logic [4:0]               shamt;
  logic                     alt;
  logic                     unused_funct3;

  assign op1_s = $signed(op1);
  assign op2_s = $signed(op2);
  assign shamt = op2[4:0];
  assign alt   = (funct7 == FUNCT7_ALT);
  // Operation selection is fully carried by alu_ctrl; funct3 is accepted for interface compatibility.
  assign unused_funct3 = ^funct3;

  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_ADD:  result = alt ? (op1 - op2) : (op1 + op2);
      ALU_SLL:  result = op1 << shamt;
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, (op1_s < op2_s)};
      ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (op1 < op2)};
      ALU_XOR:  result = op1 ^ op2;
      ALU_SRL:  result = alt ? $unsigned(op1_s >>> shamt) : (op1 >> shamt);
      ALU_OR:   result = op1 | op2;
      ALU_AND:  result = op1 & op2;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU: accept, execute for one cycle, hold the response until consumed.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*DATA_W-1:0]   req_op1,
  input  logic [2*DATA_W-1:0]   req_op2,
  input  logic [5:0]            req_alu_ctrl,
  input  logic [5:0]            req_funct3,
  input  logic [13:0]           req_funct7,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [DATA_W-1:0]     resp_result,
  output logic                  resp_zero,
  output logic                  busy,
  output logic [CNT_W-1:0]      ops_done
);

  state_e            state;
  logic              g;
  logic              prio;
  logic              gnt;
  logic              accept;

  logic [DATA_W-1:0] op1_p0;
  logic [DATA_W-1:0] op2_p0;
  logic [2:0]        alu_ctrl_p0;
  logic [2:0]        funct3_p0;
  logic [6:0]        funct7_p0;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;
  logic [DATA_W-1:0] res_p1;
  logic              zero_p1;

  // Contention goes to the priority pointer; otherwise the lone requester wins.
  assign gnt    = (&req_valid) ? prio : req_valid[1];
  assign accept = (state == ST_IDLE) && (|req_valid);

  always_comb begin
    req_ready = 2'b00;
    if (accept && rst_n)
      req_ready[gnt] = 1'b1;
  end

  // Stage p0: latch the granted request's operands at accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      op1_p0      <= gnt ? req_op1[2*DATA_W-1:DATA_W] : req_op1[DATA_W-1:0];
      op2_p0      <= gnt ? req_op2[2*DATA_W-1:DATA_W] : req_op2[DATA_W-1:0];
      alu_ctrl_p0 <= gnt ? req_alu_ctrl[5:3] : req_alu_ctrl[2:0];
      funct3_p0   <= gnt ? req_funct3[5:3]   : req_funct3[2:0];
      funct7_p0   <= gnt ? req_funct7[13:7]  : req_funct7[6:0];
    end
  end

  alu #(.DATA_W(DATA_W)) u_alu (
    .op1      (op1_p0),
    .op2      (op2_p0),
    .alu_ctrl (alu_ctrl_p0),
    .funct3   (funct3_p0),
    .funct7   (funct7_p0),
    .result   (alu_res),
    .zero     (alu_zero)
  );

  // Stage p1: capture the ALU output during EXEC.
  always_ff @(posedge clk) begin
    if (state == ST_EXEC) begin
      res_p1  <= alu_res;
      zero_p1 <= alu_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      g          <= 1'b0;
      prio       <= 1'b0;
      ops_done   <= '0;
      resp_valid <= 2'b00;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            g     <= gnt;
            busy  <= 1'b1;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_valid[g] <= 1'b1;
          state         <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready[g]) begin
            resp_valid <= 2'b00;
            prio       <= ~g;
            ops_done   <= ops_done + 1'b1;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The shared result bus reads as zero whenever no response is offered.
  assign resp_result = (|resp_valid) ? res_p1 : '0;
  assign resp_zero   = (|resp_valid) & zero_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level reference model plus directed literal checks.
module tb_alu_arbiter;

  localparam int DATA_W = 32;
  // Narrow counter so the wrap-around is reachable in a short run.
  localparam int CNT_W  = 10;

  logic              clk;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [63:0]       req_op1;
  logic [63:0]       req_op2;
  logic [5:0]        req_alu_ctrl;
  logic [5:0]        req_funct3;
  logic [13:0]       req_funct7;
  logic [1:0]        resp_valid;
  logic [1:0]        resp_ready;
  logic [31:0]       resp_result;
  logic              resp_zero;
  logic              busy;
  logic [CNT_W-1:0]  ops_done;

  int tests = 0;
  int fails = 0;

  alu_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .req_alu_ctrl (req_alu_ctrl),
    .req_funct3   (req_funct3),
    .req_funct7   (req_funct7),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_result  (resp_result),
    .resp_zero    (resp_zero),
    .busy         (busy),
    .ops_done     (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference ALU written from the instruction semantics.
  function automatic logic [31:0] ref_alu(input logic [2:0] c, input logic [31:0] a,
                                          input logic [31:0] b, input logic [6:0] f7);
    int   sh;
    logic alt;
    sh  = int'(b[4:0]);
    alt = (f7 == 7'h20);
    case (c)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, a < b};
      3'd3: return {31'b0, a < b};
      3'd4: return a ^ b;
      3'd5: return alt ? ((a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0)) : (a >> sh);
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Transaction model: one pending op, its owner, age since accept, expected result.
  logic             m_pend = 1'b0;
  logic             m_who  = 1'b0;
  logic             m_prio = 1'b0;
  int               m_age  = 0;
  logic [31:0]      m_exp  = '0;
  logic [CNT_W-1:0] m_cnt  = '0;
  logic             m_gnt;

  assign m_gnt = (&req_valid) ? m_prio : req_valid[1];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 1'b0;
      m_prio <= 1'b0;
      m_cnt  <= '0;
      m_age  <= 0;
    end else if (!m_pend) begin
      if (|req_valid) begin
        m_pend <= 1'b1;
        m_who  <= m_gnt;
        m_age  <= 0;
        m_exp  <= m_gnt ? ref_alu(req_alu_ctrl[5:3], req_op1[63:32], req_op2[63:32], req_funct7[13:7])
                        : ref_alu(req_alu_ctrl[2:0], req_op1[31:0], req_op2[31:0], req_funct7[6:0]);
      end
    end else if (m_age >= 1 && resp_ready[m_who]) begin
      m_pend <= 1'b0;
      m_prio <= ~m_who;
      m_cnt  <= m_cnt + 1'b1;
    end else if (m_age < 2) begin
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    logic        vis;
    logic [1:0]  e_ready;
    logic [1:0]  e_vld;
    vis     = m_pend && (m_age >= 1);
    e_ready = (!m_pend && rst_n && (|req_valid)) ? (m_gnt ? 2'b10 : 2'b01) : 2'b00;
    e_vld   = vis ? (m_who ? 2'b10 : 2'b01) : 2'b00;
    chk("cyc_req_ready", req_ready, e_ready);
    chk("cyc_resp_valid", resp_valid, e_vld);
    chk("cyc_resp_result", resp_result, vis ? m_exp : 32'h0);
    chk("cyc_resp_zero", resp_zero, vis && (m_exp == 32'h0));
    chk("cyc_busy", busy, m_pend);
    chk("cyc_ops_done", ops_done, m_cnt);
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] c, input logic [6:0] f7);
    if (i == 0) begin
      req_op1[31:0] = a; req_op2[31:0] = b; req_alu_ctrl[2:0] = c;
      req_funct3[2:0] = 3'($urandom_range(0, 7)); req_funct7[6:0] = f7;
    end else begin
      req_op1[63:32] = a; req_op2[63:32] = b; req_alu_ctrl[5:3] = c;
      req_funct3[5:3] = 3'($urandom_range(0, 7)); req_funct7[13:7] = f7;
    end
  endtask

  task automatic wait_resp(input int idx, output int n);
    logic seen;
    seen = 1'b0;
    n = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      n++;
      if (resp_valid[idx]) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL resp_timeout: requester %0d got no resp_valid, expected one within 20 cycles", idx);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    resp_ready = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [6:0] pick_f7();
    if ($urandom_range(0, 2) == 0) return 7'h20;
    return ($urandom_range(0, 1) != 0) ? 7'h00 : 7'($urandom_range(0, 127));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    req_valid = 2'b11;
    resp_ready = 2'b00;
    req_op1 = '0; req_op2 = '0; req_alu_ctrl = '0; req_funct3 = '0; req_funct7 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp_valid", resp_valid, 2'b00);
    chk("rst_result", resp_result, 32'h0);
    chk("rst_ops_done", ops_done, '0);
    req_valid = 2'b00;
    @(posedge clk); #1 rst_n = 1'b1;

    // ADD 5+3 on requester 0
    @(posedge clk); #1;
    set_req(0, 32'd5, 32'd3, 3'b000, 7'h00);
    req_valid = 2'b01; resp_ready = 2'b11;
    @(posedge clk); #1 req_valid = 2'b00;
    wait_resp(0, n);
    chk("add_latency", n, 2);
    chk("add_result", resp_result, 32'h8);
    chk("add_zero", resp_zero, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("add_ops_done", ops_done, 1);

    // SUB 3-3 on requester 1
    @(posedge clk); #1;
    set_req(1, 32'd3, 32'd3, 3'b000, 7'h20);
    req_valid = 2'b10;
    @(posedge clk); #1 req_valid = 2'b00;
    wait_resp(1, n);
    chk("sub_result", resp_result, 32'h0);
    chk("sub_zero", resp_zero, 1'b1);
    chk("sub_valid", resp_valid, 2'b10);
    @(posedge clk); #1;

    // Contention straight out of reset
    do_reset();
    set_req(0, 32'hFFFF_FFFE, 32'h1, 3'b010, 7'h00);
    set_req(1, 32'hFFFF_FFFE, 32'h1, 3'b010, 7'h00);
    req_valid = 2'b11; resp_ready = 2'b11;
    @(negedge clk);
    chk("arb_first_grant", req_ready, 2'b01);
    wait_resp(0, n);
    chk("slt_req0_result", resp_result, 32'h1);
    @(negedge clk);
    chk("arb_second_grant", req_ready, 2'b10);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_resp(1, n);
    chk("slt_req1_result", resp_result, 32'h1);
    @(posedge clk); #1;

    // SRA with back-pressure; requester 1 waits, its resp_ready is ignored
    set_req(0, 32'h8000_0000, 32'h4, 3'b101, 7'h20);
    set_req(1, 32'h1234_5678, 32'h4, 3'b100, 7'h00);
    req_valid = 2'b11; resp_ready = 2'b10;
    @(posedge clk); #1 req_valid = 2'b10;
    wait_resp(0, n);
    chk("sra_result", resp_result, 32'hF800_0000);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("sra_hold_result", resp_result, 32'hF800_0000);
      chk("sra_hold_req_ready", req_ready, 2'b00);
    end
    @(posedge clk); #1 resp_ready = 2'b01;
    @(posedge clk); #1 req_valid = 2'b00; resp_ready = 2'b00;
    @(negedge clk);
    chk("sra_done_busy", busy, 1'b0);

    // Reset during EXEC discards the operation
    @(posedge clk); #1;
    set_req(0, 32'd7, 32'd9, 3'b000, 7'h00);
    req_valid = 2'b01; resp_ready = 2'b01;
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    chk("exec_rst_busy", busy, 1'b0);
    chk("exec_rst_ops_done", ops_done, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("exec_rst_no_resp", resp_valid, 2'b00);
    end

    // Randomized traffic, occasional reset
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      rst_n = ($urandom_range(0, 199) != 0);
      req_valid = 2'($urandom_range(0, 3));
      resp_ready = 2'($urandom_range(0, 3));
      set_req(0, pick_op(), pick_op(), 3'($urandom_range(0, 7)), pick_f7());
      set_req(1, pick_op(), pick_op(), 3'($urandom_range(0, 7)), pick_f7());
    end
    @(posedge clk); #1 rst_n = 1'b1;

    // Counter wrap
    do_reset();
    set_req(0, 32'd1, 32'd2, 3'b000, 7'h00);
    set_req(1, 32'd4, 32'd4, 3'b111, 7'h00);
    req_valid = 2'b11; resp_ready = 2'b11;
    for (int k = 0; k < 4000 && ops_done != {CNT_W{1'b1}}; k++) @(negedge clk);
    chk("cnt_at_max", ops_done, {CNT_W{1'b1}});
    for (int k = 0; k < 10 && ops_done == {CNT_W{1'b1}}; k++) @(negedge clk);
    chk("cnt_wrap", ops_done, '0);
    req_valid = 2'b00;
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; SHALL match the ALU datapath width.
REQ-002 Parameter CNT_W, default 16, width of completed-operation counter.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-006 req_ready  output  2  per-requester accept; at most one bit high per cycle.
REQ-007 req_op1, req_op2  input  2xDATA_W  per-requester operands.
REQ-008 req_alu_ctrl  input  2x3  per-requester ALUControl code.
REQ-009 req_funct3  input  2x3; req_funct7  input  2x7  per-requester function fields.
REQ-010 resp_valid  output  2  per-requester result valid; at most one bit high per cycle.
REQ-011 resp_ready  input  2  per-requester result consume.
REQ-012 resp_result  output  DATA_W  result, shared bus, meaningful only with resp_valid.
REQ-013 resp_zero  output  1  ALU zero flag for resp_result.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 ops_done  output  CNT_W  count of completed responses.

Function
REQ-016 FSM states: IDLE, EXEC, RESP.
REQ-017 IDLE: req_ready SHALL be high, combinationally, only for the granted requester when at least one req_valid is high.
REQ-018 Grant: single valid -> that requester; both valid -> requester indicated by priority pointer prio.
REQ-019 Accept (valid&&ready in IDLE): latch op1, op2, alu_ctrl, funct3, funct7 and grant index g; go EXEC.
REQ-020 EXEC (exactly one cycle): ALU evaluates latched operands; register result and zero; go RESP.
REQ-021 RESP: resp_valid[g]=1, resp_result/resp_zero stable until resp_ready[g]; no new request accepted.
REQ-022 On resp_valid[g]&&resp_ready[g]: prio <= ~g, ops_done += 1 (wraps to 0 at max), go IDLE.
REQ-023 Latency: accept at edge N -> resp_valid high from cycle N+2; minimum 3 cycles per operation.
REQ-024 resp_ready of the non-granted requester, and req inputs outside IDLE, SHALL be ignored.
REQ-025 ALU semantics: ALUControl 000 ADD, or SUB when funct7=0100000; 001 SLL; 010 SLT signed; 011 SLTU; 100 XOR; 101 SRL, or SRA when funct7=0100000; 110 OR; 111 AND; shift amount = op2[4:0]; zero=1 iff result==0.
REQ-026 resp_result SHALL be 0 and resp_zero 0 whenever no resp_valid bit is high.

Reset
REQ-027 Reset SHALL force: state IDLE, prio=0, ops_done=0, req_ready=0 (until deassertion), resp_valid=0, resp_result=0, resp_zero=0, busy=0.
REQ-028 Reset asserted mid-EXEC or mid-RESP SHALL discard the operation without a response or counter increment.

Structure
REQ-029 Shared package alu_pkg SHALL hold ALUControl encodings, FUNCT7_ALT (0100000) constant and the FSM state enum.
REQ-030 The existing ALU module SHALL be instantiated once as the sole sub-module, fed from latched registers only.

Verification
REQ-031 Req0 ADD 5+3, resp_ready=1 -> resp_valid[0] at accept+2, result 0x00000008, zero 0, ops_done 1.
REQ-032 Req1 SUB (funct7 0100000) 0x3-0x3 -> result 0x00000000, zero 1 on resp_valid[1].
REQ-033 Both valid from reset (prio=0), both SLT 0xFFFFFFFE vs 0x1 -> req0 served first result 1, then req1 result 1; next both-valid round grants req1 first.
REQ-034 Req0 SRA 0x80000000>>4, resp_ready low 5 cycles -> result 0xF8000000 held stable, req1 valid stays not-ready until handshake.
REQ-035 rst_n low during EXEC -> resp_valid never asserts, ops_done 0, busy 0 immediately.
REQ-036 Force 65536 completed ops (CNT_W=16) -> ops_done wraps 0xFFFF -> 0x0000.
